// File: rtl/dmem_lsu_if.sv
// rtl/dmem_lsu_if.sv - CPU request/response and data-memory bundles for the load/store unit
// The CPU side masters lsu_req_if; the LSU masters lsu_mem_if towards the data memory.

interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output mem_write, mem_read, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_write, mem_read, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - single-outstanding load/store unit in front of a word-addressed data memory
// Sub-word stores are read-modify-write; loads extract a little-endian lane and extend it.

module dmem_lsu #(
  parameter logic [31:0] BASE_ADDR   = 32'h2000,
  parameter int unsigned DEPTH_WORDS = 512
) (
  input  logic      clock,
  input  logic      reset_n,
  lsu_req_if.slave  cpu,
  lsu_mem_if.master mem
);

  localparam logic [1:0]  SIZE_BYTE = 2'b00;
  localparam logic [1:0]  SIZE_HALF = 2'b01;
  localparam logic [1:0]  SIZE_WORD = 2'b10;
  // 33-bit window bounds so a window ending at 4 GiB cannot wrap
  localparam logic [32:0] WIN_LO    = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI    = WIN_LO + 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req_ready;
  logic        resp_valid;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        req_fire;
  logic        req_err;

  function automatic logic [31:0] extract_load(
    input logic [31:0] word,
    input logic [1:0]  lane,
    input logic [1:0]  size,
    input logic        sgn
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'h00;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: r = sgn ? {{24{b[7]}}, b} : {24'h000000, b};
      SIZE_HALF: r = sgn ? {{16{h[15]}}, h} : {16'h0000, h};
      default:   r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(
    input logic [31:0] word,
    input logic [31:0] data,
    input logic [1:0]  lane,
    input logic [1:0]  size
  );
    logic [31:0] r;
    r = word;
    case (size)
      SIZE_BYTE: begin
        case (lane)
          2'd0:    r[7:0]   = data[7:0];
          2'd1:    r[15:8]  = data[7:0];
          2'd2:    r[23:16] = data[7:0];
          default: r[31:24] = data[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (lane[1]) r[31:16] = data[15:0];
        else         r[15:0]  = data[15:0];
      end
      default:   r = data;
    endcase
    return r;
  endfunction

  // Classify the incoming request so the accepting edge can already pick the next state
  always_comb begin
    req_err = 1'b0;
    case (cpu.req_size)
      SIZE_BYTE: req_err = 1'b0;
      SIZE_HALF: req_err = cpu.req_addr[0];
      SIZE_WORD: req_err = |cpu.req_addr[1:0];
      default:   req_err = 1'b1;
    endcase
    if (({1'b0, cpu.req_addr} < WIN_LO) || ({1'b0, cpu.req_addr} >= WIN_HI)) begin
      req_err = 1'b1;
    end
  end

  assign req_fire = cpu.req_valid & req_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (cpu.req_valid) begin
          if (req_err)
            state_d = RESP;
          else if (cpu.req_write && cpu.req_size == SIZE_WORD)
            state_d = WR;
          else
            state_d = RD;
        end
      end
      RD: begin
        mem_read = 1'b1;
        mem_addr = {addr_q[31:2], 2'b00};
        state_d  = write_q ? WR : RESP;
      end
      WR: begin
        mem_write = 1'b1;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_wdata = merge_store(word_q, wdata_q, addr_q[1:0], size_q);
        state_d   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (cpu.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Captured request, fetched word and the response payload
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      word_q   <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      if (req_fire) begin
        write_q  <= cpu.req_write;
        size_q   <= cpu.req_size;
        signed_q <= cpu.req_signed;
        addr_q   <= cpu.req_addr;
        wdata_q  <= cpu.req_wdata;
        rdata_q  <= 32'h0;
        err_q    <= req_err;
      end
      if (state_q == RD) begin
        word_q <= mem.mem_rdata;
        if (!write_q) rdata_q <= extract_load(mem.mem_rdata, addr_q[1:0], size_q, signed_q);
      end
    end
  end

  assign cpu.req_ready  = req_ready;
  assign cpu.resp_valid = resp_valid;
  assign cpu.resp_rdata = rdata_q;
  assign cpu.resp_err   = err_q;

  assign mem.mem_read   = mem_read;
  assign mem.mem_write  = mem_write;
  assign mem.mem_addr   = mem_addr;
  assign mem.mem_wdata  = mem_wdata;

endmodule
